// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin mux arbiter.
//   state_e        : arbiter FSM encoding (IDLE = 1'b0, BUSY = 1'b1)
//   DEF_N          : default number of requesters / mux inputs
//   DEF_DATA_W     : default width of one mux data input
//   DEF_MAX_BURST  : default beat limit per grant (only used when the
//                    ARB_BURST_LIMIT_EN macro is defined)
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned DEF_N         = 8;
  localparam int unsigned DEF_DATA_W    = 1;
  localparam int unsigned DEF_MAX_BURST = 4;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. Starting at i_ptr+1 and wrapping
// modulo N, it returns the first index whose request bit is set. The search
// covers all N positions, so i_ptr itself is picked last (when it is the only
// requester).
// Ports:
//   i_req   [N-1:0]      request vector
//   i_ptr   [SEL_W-1:0]  last owner; it gets lowest priority
//   o_found              at least one request is set
//   o_idx   [SEL_W-1:0]  winning index (0 when o_found is low)
// N must be a power of two so that SEL_W-bit addition wraps modulo N.
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W-1:0] w_cand;

  // Walk from the farthest offset (N, i.e. i_ptr itself) down to the nearest
  // (1), so the last hit written is the closest one after i_ptr.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = int'(N); k > 0; k--) begin
      w_cand = i_ptr + SEL_W'(k);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Shares one N:1 data mux between N requesters with round-robin arbitration.
// The winner is registered (sel / one-hot gnt) and its beats are forwarded
// downstream over a valid/ready handshake.
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-high
//   req        [N]         req[i]: requester i has a beat on din slice i
//   din        [N*DATA_W]  packed mux inputs, slice i = din[i*DATA_W +: DATA_W]
//   gnt        [N]         registered one-hot grant, zero when idle
//   sel        [SEL_W]     registered mux select = current owner
//   ack        [N]         ack[owner] = out_valid & out_ready (combinational)
//   out_valid              dout holds a valid beat
//   out_ready              downstream accepts a beat this cycle
//   dout       [DATA_W]    din slice selected by sel
// Configuration:
//   ARB_BURST_LIMIT_EN  defined: a grant is force-released on its MAX_BURST-th
//                       accepted beat. Undefined: the owner keeps the grant
//                       until it drops its request.
// -----------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned SEL_W     = $clog2(N),
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*DATA_W-1:0] din,
  output logic [N-1:0]        gnt,
  output logic [SEL_W-1:0]    sel,
  output logic [N-1:0]        ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   dout
);

  state_e           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel,   w_sel_nxt;
  logic [SEL_W-1:0] r_ptr,   w_ptr_nxt;
  logic [N-1:0]     r_gnt,   w_gnt_nxt;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_owner_req;
  logic             w_accept;
  logic             w_burst_done;
  logic             w_release;
  logic [DATA_W-1:0] w_din_arr [N];

  // Unpack the flat data bus so the output mux is a plain array index.
  for (genvar i = 0; i < N; i++) begin : g_din
    assign w_din_arr[i] = din[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // ---------------------------------------------------------------------------
  // Handshake. Reset forces r_state to IDLE asynchronously, so out_valid and
  // ack drop in the same instant reset is asserted.
  // ---------------------------------------------------------------------------
  assign w_owner_req = req[r_sel];
  assign out_valid   = (r_state == BUSY) && w_owner_req;
  assign w_accept    = out_valid && out_ready;
  assign dout        = w_din_arr[r_sel];
  assign gnt         = r_gnt;
  assign sel         = r_sel;

  always_comb begin
    ack = '0;
    if (w_accept) ack[r_sel] = 1'b1;
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  // The acceptance that brings the count to MAX_BURST ends the grant.
  assign w_burst_done = w_accept && (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    w_beat_cnt_nxt = r_beat_cnt;
    if (r_state == IDLE && w_found) w_beat_cnt_nxt = '0;
    else if (w_accept)              w_beat_cnt_nxt = r_beat_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_beat_cnt <= '0;
    else     r_beat_cnt <= w_beat_cnt_nxt;
  end
`else
  assign w_burst_done = 1'b0;
`endif

  // A grant ends when the owner drops its request (any beat still pending is
  // simply not offered) or when the burst limit is reached.
  assign w_release = (r_state == BUSY) && (!w_owner_req || w_burst_done);

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = w_idx;
          w_gnt_nxt   = N'(1) << w_idx;
        end
      end
      BUSY: begin
        // Releasing owner becomes the pointer, so it has lowest priority next.
        if (w_release) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register. ptr resets to N-1 so requester 0 has top priority.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(N - 1);
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

endmodule : mux_rr_arbiter
